// File: rtl/distram_fifo_axis_reader.sv
// Read-side consumer for the distributed-RAM FIFO: issues credit-limited reads and
// re-times the fixed-latency read data into an AXI4-Stream master through a skid buffer.
module distram_fifo_axis_reader #(
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 2,
    parameter int BUF_DEPTH    = 4,
    parameter int CNT_BITS     = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CNT_BITS-1:0]   buf_count,
    output logic                  overflow_err
);

    localparam int PTR_BITS = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_BITS:0]   DEPTH_WIDE = (CNT_BITS + 1)'(BUF_DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_CNT  = CNT_BITS'(BUF_DEPTH);

    if (BUF_DEPTH < READ_LATENCY + 2) begin : g_depth_check
        $error("BUF_DEPTH must be at least READ_LATENCY+2");
    end
    if ((1 << (CNT_BITS - 1)) < BUF_DEPTH) begin : g_cnt_check
        $error("CNT_BITS too narrow for BUF_DEPTH");
    end

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   buf_count_q, buf_count_d;
    logic [CNT_BITS-1:0]   inflight_q, inflight_d;
    logic                  overflow_q, overflow_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic [CNT_BITS:0]     credit_used;

    // A read is only issued when every outstanding read plus every buffered beat
    // still leaves a free slot, so returning data always has somewhere to land.
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, buf_count_q};
        fifo_re     = reset_n & ~fifo_empty & (credit_used < DEPTH_WIDE);
    end

    // AXI-S handshake: a beat transfers on a cycle where tvalid and tready are both
    // high; tvalid never drops and tdata never changes until that transfer happens.
    always_comb begin
        full = (buf_count_q == DEPTH_CNT);
        pop  = (buf_count_q != '0) & m_axis_tready;
        push = fifo_valid & (~full | pop);

        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        buf_count_d = buf_count_q;
        inflight_d  = inflight_q;
        overflow_d  = overflow_q;

        // When full with a pop, wr_ptr equals rd_ptr: the outgoing beat is consumed
        // this cycle, so overwriting its slot at the edge is safe.
        if (push) begin
            buf_d[wr_ptr_q] = fifo_dout;
            wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end

        case ({push, pop})
            2'b10:   buf_count_d = buf_count_q + CNT_BITS'(1);
            2'b01:   buf_count_d = buf_count_q - CNT_BITS'(1);
            default: buf_count_d = buf_count_q;
        endcase

        if (fifo_valid & full & ~pop) begin
            overflow_d = 1'b1;
        end

        case ({fifo_re, fifo_valid})
            2'b10:   inflight_d = inflight_q + CNT_BITS'(1);
            2'b01:   inflight_d = inflight_q - CNT_BITS'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            buf_count_q <= '0;
            inflight_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_count_q <= buf_count_d;
            inflight_q  <= inflight_d;
            overflow_q  <= overflow_d;
        end
    end

    assign m_axis_tvalid = (buf_count_q != '0);
    assign m_axis_tdata  = buf_q[rd_ptr_q];
    assign buf_count     = buf_count_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_distram_fifo_axis_reader.sv
// Directed bench for distram_fifo_axis_reader: a behavioural FIFO with a two-cycle
// read pipeline feeds the DUT, and an expected-data queue checks every output beat.
module tb_distram_fifo_axis_reader;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_re;
    logic          fifo_valid;
    logic [DW-1:0] fifo_dout;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [2:0]    buf_count;
    logic          overflow_err;

    distram_fifo_axis_reader #(
        .DATA_WIDTH(DW), .READ_LATENCY(2), .BUF_DEPTH(4), .CNT_BITS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fifo_empty(fifo_empty), .fifo_re(fifo_re),
        .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .buf_count(buf_count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model: read data returns two cycles after re ----------------
    logic [DW-1:0] fifo_q[$];
    logic          acc = 1'b0;
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [DW-1:0] p1_d = '0, p2_d = '0;
    logic          inj_valid = 1'b0;
    logic [DW-1:0] inj_data = '0;

    assign fifo_valid = p2_v | inj_valid;
    assign fifo_dout  = inj_valid ? inj_data : p2_d;

    always @(negedge clk) acc = fifo_re & ~fifo_empty;

    always @(posedge clk) begin
        if (!reset_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
        end else begin
            p1_v <= acc;
            if (acc) p1_d <= fifo_q.pop_front();
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [DW-1:0] exp_q[$];
    int   cyc = 0;
    int   beats = 0, first_beat = -1, last_beat = -1;
    int   max_inflight = 0;
    int   simul_seen = 0;
    logic cnt_chk_en = 1'b0;
    logic prev_ok = 1'b0;
    int   prev_count = 0;
    logic prev_push = 1'b0, prev_pop = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (int'(dut.inflight_q) > max_inflight) max_inflight = int'(dut.inflight_q);
            if (m_axis_tvalid && m_axis_tready) begin
                check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check_eq("beat_data", m_axis_tdata, exp_q.pop_front());
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                if (fifo_valid) simul_seen++;
            end
            if (cnt_chk_en && prev_ok)
                check_eq("count_step", 64'(buf_count),
                         64'(prev_count + int'(prev_push) - int'(prev_pop)));
            prev_pop   = m_axis_tvalid & m_axis_tready;
            prev_push  = fifo_valid & ((buf_count != 3'd4) | prev_pop);
            prev_count = int'(buf_count);
            prev_ok    = cnt_chk_en;
        end else begin
            prev_ok = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_stats();
        beats        = 0;
        first_beat   = -1;
        last_beat    = -1;
        max_inflight = 0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with a word already waiting in the FIFO
        m_axis_tready = 1'b1;
        load_word(64'hA5);
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_fifo_re",  64'(fifo_re), 64'd0);
        check_eq("rst_tvalid",   64'(m_axis_tvalid), 64'd0);
        check_eq("rst_count",    64'(buf_count), 64'd0);
        check_eq("rst_overflow", 64'(overflow_err), 64'd0);
        check_eq("rst_tdata",    m_axis_tdata, 64'd0);

        // Single word: re in cycle 0, tvalid only in cycle 3
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq($sformatf("single_re_c%0d", c), 64'(fifo_re), 64'(c == 0));
            check_eq($sformatf("single_tvalid_c%0d", c), 64'(m_axis_tvalid), 64'(c == 3));
            if (c == 3) check_eq("single_tdata", m_axis_tdata, 64'hA5);
        end

        // Streaming 32 words with tready held high
        tick();
        clear_stats();
        for (int i = 0; i < 32; i++) load_word(64'(i));
        wait_drain(300, "stream_drain");
        check_eq("stream_beats", 64'(beats), 64'd32);
        check_eq("stream_no_bubbles", 64'(last_beat - first_beat), 64'd31);
        check_eq("stream_inflight_max", 64'(max_inflight), 64'd2);

        // Backpressure: 20 words, tready low
        tick();
        m_axis_tready = 1'b0;
        clear_stats();
        for (int i = 0; i < 20; i++) load_word(64'(100 + i));
        repeat (12) @(negedge clk);
        check_eq("bp_count",     64'(buf_count), 64'd4);
        check_eq("bp_fifo_re",   64'(fifo_re), 64'd0);
        check_eq("bp_inflight",  64'(dut.inflight_q), 64'd0);
        check_eq("bp_tvalid",    64'(m_axis_tvalid), 64'd1);
        check_eq("bp_tdata",     m_axis_tdata, 64'd100);
        check_eq("bp_fifo_left", 64'(fifo_q.size()), 64'd16);
        tick();
        m_axis_tready = 1'b1;
        wait_drain(300, "bp_drain");
        check_eq("bp_beats", 64'(beats), 64'd20);

        // Random tready over 1000 words
        tick();
        clear_stats();
        simul_seen = 0;
        cnt_chk_en = 1'b1;
        for (int i = 0; i < 1000; i++) load_word({$urandom(), $urandom()});
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) begin
            tick();
            m_axis_tready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cnt_chk_en = 1'b0;
        check_eq("rand_drain",       64'(exp_q.size()), 64'd0);
        check_eq("rand_beats",       64'(beats), 64'd1000);
        check_eq("rand_simul_seen",  64'(simul_seen > 0), 64'd1);
        check_eq("rand_overflow",    64'(overflow_err), 64'd0);

        // Error injection into a full buffer
        tick();
        m_axis_tready = 1'b0;
        clear_stats();
        for (int i = 0; i < 4; i++) load_word(64'(200 + i));
        repeat (12) @(negedge clk);
        check_eq("inj_pre_count",    64'(buf_count), 64'd4);
        check_eq("inj_pre_overflow", 64'(overflow_err), 64'd0);
        @(posedge clk);
        #1;
        inj_data  = 64'hDEAD_BEEF;
        inj_valid = 1'b1;
        @(posedge clk);
        #1 inj_valid = 1'b0;
        @(negedge clk);
        check_eq("inj_overflow", 64'(overflow_err), 64'd1);
        check_eq("inj_count",    64'(buf_count), 64'd4);
        check_eq("inj_tdata",    m_axis_tdata, 64'd200);
        repeat (5) @(negedge clk);
        check_eq("inj_sticky", 64'(overflow_err), 64'd1);
        tick();
        m_axis_tready = 1'b1;
        wait_drain(50, "inj_drain");
        repeat (3) @(negedge clk);
        check_eq("inj_beats",        64'(beats), 64'd4);
        check_eq("inj_sticky_after", 64'(overflow_err), 64'd1);

        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check_eq("rst2_overflow", 64'(overflow_err), 64'd0);
        check_eq("rst2_count",    64'(buf_count), 64'd0);
        check_eq("rst2_tvalid",   64'(m_axis_tvalid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
